// File: rtl/pc_fetch_unit.sv
// Program counter for the instruction memory: next-PC select (seq/branch/jump), RUN/HALT/FAULT control.
// pc and state are registered (1 cycle); pc_plus4 is combinational; stall holds PC and the retire count.
module pc_fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          IMEM_DEPTH = 100,
   parameter logic [31:0] HALT_INSTR = 32'hFFFF_FFFF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic        jump,
   input  logic [31:0] sign_imm,
   input  logic [31:0] instr,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic        halted,
   output logic        addr_fault,
   output logic [31:0] retired_cnt
);

   localparam logic [1:0] S_RUN   = 2'b00;
   localparam logic [1:0] S_HALT  = 2'b01;
   localparam logic [1:0] S_FAULT = 2'b10;

   localparam logic [31:0] DEPTH_W = 32'(IMEM_DEPTH);

   logic [1:0]  state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] cnt_q, cnt_d;
   logic [31:0] br_target;
   logic [31:0] jmp_target;
   logic [31:0] next_pc;
   logic [31:0] cnt_sat;
   logic        next_oob;
   logic        unused_imm_hi;

   // Offset is in words; its top two bits shift out of range.
   assign unused_imm_hi = ^sign_imm[31:30];

   assign pc_plus4   = pc_q + 32'd4;
   assign br_target  = pc_plus4 + {sign_imm[29:0], 2'b00};
   assign jmp_target = {pc_plus4[31:28], instr[25:0], 2'b00};
   assign next_pc    = jump ? jmp_target : (branch_taken ? br_target : pc_plus4);
   assign next_oob   = {2'b00, next_pc[31:2]} >= DEPTH_W;
   assign cnt_sat    = (cnt_q == 32'hFFFF_FFFF) ? cnt_q : cnt_q + 32'd1;

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_RUN: begin
            if (!stall) begin
               cnt_d = cnt_sat;
               if (instr == HALT_INSTR) begin
                  state_d = S_HALT;
               end else if (next_oob) begin
                  state_d = S_FAULT;
               end else begin
                  pc_d = next_pc;
               end
            end
         end
         S_HALT:  state_d = S_HALT;
         S_FAULT: state_d = S_FAULT;
         default: state_d = S_FAULT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_RUN;
         pc_q    <= RESET_PC;
         cnt_q   <= 32'd0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         cnt_q   <= cnt_d;
      end
   end

   assign pc          = pc_q;
   assign retired_cnt = cnt_q;
   assign halted      = (state_q == S_HALT);
   assign addr_fault  = (state_q == S_FAULT);

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: one task per scenario with hand-computed expectations.
module tb_pc_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall;
   logic        branch_taken;
   logic        jump;
   logic [31:0] sign_imm;
   logic [31:0] instr;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        halted;
   logic        addr_fault;
   logic [31:0] retired_cnt;

   int checks = 0;
   int errors = 0;

   pc_fetch_unit dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .stall        (stall),
      .branch_taken (branch_taken),
      .jump         (jump),
      .sign_imm     (sign_imm),
      .instr        (instr),
      .pc           (pc),
      .pc_plus4     (pc_plus4),
      .halted       (halted),
      .addr_fault   (addr_fault),
      .retired_cnt  (retired_cnt)
   );

   always #5 clk = ~clk;

   // One rising edge, then settle before sampling or driving.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic s, input logic b, input logic j,
                        input logic [31:0] imm, input logic [31:0] ins);
      stall        = s;
      branch_taken = b;
      jump         = j;
      sign_imm     = imm;
      instr        = ins;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      step();
      step();
      checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp %h", pc, 32'h0); end
      checks++; if (pc_plus4 !== 32'h4) begin errors++; $display("FAIL reset_pc_plus4 got %h exp %h", pc_plus4, 32'h4); end
      checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %b exp 0", halted); end
      checks++; if (addr_fault !== 1'b0) begin errors++; $display("FAIL reset_fault got %b exp 0", addr_fault); end
      checks++; if (retired_cnt !== 32'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", retired_cnt); end
   endtask

   task automatic test_sequential();
      rst_n = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      step();
      checks++; if (pc !== 32'h4) begin errors++; $display("FAIL seq_pc1 got %h exp %h", pc, 32'h4); end
      step();
      checks++; if (pc !== 32'h8) begin errors++; $display("FAIL seq_pc2 got %h exp %h", pc, 32'h8); end
      step();
      checks++; if (pc !== 32'hC) begin errors++; $display("FAIL seq_pc3 got %h exp %h", pc, 32'hC); end
      checks++; if (retired_cnt !== 32'd3) begin errors++; $display("FAIL seq_cnt got %0d exp 3", retired_cnt); end
      checks++; if (pc_plus4 !== 32'h10) begin errors++; $display("FAIL seq_pc_plus4 got %h exp %h", pc_plus4, 32'h10); end
      step();
      checks++; if (pc !== 32'h10) begin errors++; $display("FAIL seq_pc4 got %h exp %h", pc, 32'h10); end
   endtask

   task automatic test_branch();
      // 0x10 + 4 - 8 = 0x0C
      drive(1'b0, 1'b1, 1'b0, 32'hFFFF_FFFE, 32'd0);
      step();
      checks++; if (pc !== 32'hC) begin errors++; $display("FAIL br_neg got %h exp %h", pc, 32'hC); end
      drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      step();
      checks++; if (pc !== 32'h10) begin errors++; $display("FAIL br_seq got %h exp %h", pc, 32'h10); end
      // 0x10 + 4 + 12 = 0x20
      drive(1'b0, 1'b1, 1'b0, 32'd3, 32'd0);
      step();
      checks++; if (pc !== 32'h20) begin errors++; $display("FAIL br_pos got %h exp %h", pc, 32'h20); end
      checks++; if (retired_cnt !== 32'd7) begin errors++; $display("FAIL br_cnt got %0d exp 7", retired_cnt); end
   endtask

   task automatic test_jump_priority();
      drive(1'b0, 1'b0, 1'b1, 32'd0, 32'h0000_0002);
      step();
      checks++; if (pc !== 32'h8) begin errors++; $display("FAIL jmp_to8 got %h exp %h", pc, 32'h8); end
      // jump beats branch: {0, 0x5, 00} = 0x14
      drive(1'b0, 1'b1, 1'b1, 32'd3, 32'h0000_0005);
      step();
      checks++; if (pc !== 32'h14) begin errors++; $display("FAIL jmp_prio got %h exp %h", pc, 32'h14); end
      checks++; if (retired_cnt !== 32'd9) begin errors++; $display("FAIL jmp_cnt got %0d exp 9", retired_cnt); end
   endtask

   task automatic test_stall_halt();
      drive(1'b1, 1'b0, 1'b0, 32'd0, 32'hFFFF_FFFF);
      step();
      step();
      checks++; if (pc !== 32'h14) begin errors++; $display("FAIL stall_pc got %h exp %h", pc, 32'h14); end
      checks++; if (retired_cnt !== 32'd9) begin errors++; $display("FAIL stall_cnt got %0d exp 9", retired_cnt); end
      checks++; if (halted !== 1'b0) begin errors++; $display("FAIL stall_halted got %b exp 0", halted); end
      // halt beats jump in the same cycle
      drive(1'b0, 1'b1, 1'b1, 32'd1, 32'hFFFF_FFFF);
      step();
      checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_flag got %b exp 1", halted); end
      checks++; if (pc !== 32'h14) begin errors++; $display("FAIL halt_pc got %h exp %h", pc, 32'h14); end
      checks++; if (retired_cnt !== 32'd10) begin errors++; $display("FAIL halt_cnt got %0d exp 10", retired_cnt); end
      drive(1'b0, 1'b0, 1'b1, 32'd0, 32'h0000_0001);
      step();
      step();
      checks++; if (pc !== 32'h14) begin errors++; $display("FAIL halt_frozen_pc got %h exp %h", pc, 32'h14); end
      checks++; if (retired_cnt !== 32'd10) begin errors++; $display("FAIL halt_frozen_cnt got %0d exp 10", retired_cnt); end
      checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_stays got %b exp 1", halted); end
   endtask

   task automatic test_reset_mid_halt();
      rst_n = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      step();
      checks++; if (pc !== 32'h0) begin errors++; $display("FAIL rst_halt_pc got %h exp %h", pc, 32'h0); end
      checks++; if (halted !== 1'b0) begin errors++; $display("FAIL rst_halt_flag got %b exp 0", halted); end
      checks++; if (retired_cnt !== 32'd0) begin errors++; $display("FAIL rst_halt_cnt got %0d exp 0", retired_cnt); end
      rst_n = 1'b1;
      step();
      checks++; if (pc !== 32'h4) begin errors++; $display("FAIL resume_pc got %h exp %h", pc, 32'h4); end
      checks++; if (retired_cnt !== 32'd1) begin errors++; $display("FAIL resume_cnt got %0d exp 1", retired_cnt); end
   endtask

   task automatic test_fault();
      // {0, 0x63, 00} = 0x18C, the last valid word (99)
      drive(1'b0, 1'b0, 1'b1, 32'd0, 32'h0000_0063);
      step();
      checks++; if (pc !== 32'h18C) begin errors++; $display("FAIL flt_last_pc got %h exp %h", pc, 32'h18C); end
      checks++; if (addr_fault !== 1'b0) begin errors++; $display("FAIL flt_last_ok got %b exp 0", addr_fault); end
      drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      step();
      checks++; if (addr_fault !== 1'b1) begin errors++; $display("FAIL flt_flag got %b exp 1", addr_fault); end
      checks++; if (pc !== 32'h18C) begin errors++; $display("FAIL flt_pc got %h exp %h", pc, 32'h18C); end
      checks++; if (retired_cnt !== 32'd3) begin errors++; $display("FAIL flt_cnt got %0d exp 3", retired_cnt); end
      checks++; if (halted !== 1'b0) begin errors++; $display("FAIL flt_halted got %b exp 0", halted); end
      drive(1'b0, 1'b0, 1'b1, 32'd0, 32'h0000_0001);
      step();
      drive(1'b0, 1'b0, 1'b0, 32'd0, 32'hFFFF_FFFF);
      step();
      checks++; if (pc !== 32'h18C) begin errors++; $display("FAIL flt_frozen_pc got %h exp %h", pc, 32'h18C); end
      checks++; if (retired_cnt !== 32'd3) begin errors++; $display("FAIL flt_frozen_cnt got %0d exp 3", retired_cnt); end
      checks++; if (addr_fault !== 1'b1 || halted !== 1'b0) begin errors++; $display("FAIL flt_frozen_state got fault=%b halted=%b exp fault=1 halted=0", addr_fault, halted); end
   endtask

   task automatic test_branch_fault();
      rst_n = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      step();
      rst_n = 1'b1;
      // 0 + 4 + 99*4 = 0x190 is word 100, out of range
      drive(1'b0, 1'b1, 1'b0, 32'd99, 32'd0);
      step();
      checks++; if (addr_fault !== 1'b1) begin errors++; $display("FAIL brflt_flag got %b exp 1", addr_fault); end
      checks++; if (pc !== 32'h0) begin errors++; $display("FAIL brflt_pc got %h exp %h", pc, 32'h0); end
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_branch();
      test_jump_priority();
      test_stall_halt();
      test_reset_mid_halt();
      test_fault();
      test_branch_fault();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
